timer_irq: RTL
==============

# timer_irq

Memory-mapped interval timer that generates the `IRQ` line consumed by the CPU control unit. It sits on the data-memory bus beside data RAM and is driven by the same `MemRd`/`MemWr` strobes the control unit issues. It reloads a 32-bit up-counter from a programmable reload value on overflow and raises `IRQ` until software clears the status bit, typically in the interrupt handler.

## Interface
Parameters:
- BASE, 32'h4000_0000, byte address of the register block (4 words, word-aligned, BASE[3:0]=0)
- PSC_W, 16, prescaler width

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low; when reset==0 at a rising edge all registers load reset values
- MemRd  input  1  bus read strobe
- MemWr  input  1  bus write strobe
- Addr  input  32  byte address
- WriteData  input  32  write data
- ReadData  output  32  read data, combinational
- IRQ  output  1  interrupt request to the control unit, active-high level

## Operation
- Decode: hit = (Addr[31:4] == BASE[31:4]); Addr[3:2] selects the register. Addr[1:0] is ignored.
  - 0: TH, 32-bit reload value.
  - 1: TL, 32-bit counter.
  - 2: TCON, bits [2:0] = {status, irq_en, enable}; upper bits read 0.
  - 3: PSC, PSC_W bits; upper bits read 0.
- Reads: ReadData = selected register when MemRd && hit, else 32'h0.
- Prescaler: internal counter pcnt (PSC_W bits).
  - While enable=1: if pcnt==PSC, then pcnt←0 and tick=1; else pcnt←pcnt+1 and tick=0.
  - While enable=0: pcnt holds and tick=0.
  - PSC=0 gives a tick every cycle.
- Counter on tick:
  - If TL==32'hFFFF_FFFF: TL←TH (overflow). If irq_en=1, status←1.
  - Otherwise TL←TL+1, modulo 2^32.
- IRQ = status & irq_en. It is derived combinationally from registers, so it is glitch-free relative to clk.
- Writes (MemWr && hit):
  - TH←WriteData.
  - TL←WriteData and pcnt←0.
  - TCON[2:0]←WriteData[2:0].
  - PSC←WriteData[PSC_W-1:0] and pcnt←0.
- Priority and simultaneous events:
  - A TL write in the same cycle as a tick: the write wins and the tick is discarded.
  - A TCON write in the same cycle as an overflow with irq_en=1 (old value): status ends at 1. The overflow set wins, so no interrupt is lost. enable and irq_en take the written value.
  - A TH write in the same cycle as an overflow: TL loads the old TH; the new TH applies from the next overflow.
  - A PSC write in the same cycle as a tick: the tick completes on TL; pcnt←0.
  - MemRd and MemWr both high: the read returns the pre-write value and the write takes effect.
  - An access with a non-hit address has no effect and ReadData=0.
- Reset (reset==0 at an edge, including mid-count): TH=0, TL=0, TCON=0, PSC=0, pcnt=0. This gives IRQ=0 and ReadData=0 unless a read hits. Reset overrides any simultaneous write.

## Timing
- Write latency: 1 cycle. A register is visible on ReadData in the cycle after the MemWr edge.
- Read latency: 0 cycles (combinational, same cycle as MemRd).
- Tick period: PSC+1 cycles after enable or after a pcnt reset.
- Overflow to IRQ: IRQ rises in the cycle immediately following the overflow edge.
- Clearing: write TCON with bit2=0 → IRQ falls after that edge, unless an overflow coincides.
- Clearing irq_en drops IRQ in the next cycle; status is retained.

## Test plan
- Reset: hold reset=0 for 2 cycles with MemWr=1 to TH → all reads return 0 and IRQ=0.
- Basic overflow:
  - Setup: PSC=0, TH=5, TL=32'hFFFF_FFFE, then TCON=3 at edge k.
  - Required: TL=FFFF_FFFF after edge k+1; TL=5, TCON=7 and IRQ=1 after edge k+2; TL=6 after edge k+3.
  - Then write TCON=3 → IRQ=0 next cycle.
- Prescaler:
  - Setup: PSC=3, TL=0, TCON=1.
  - Required: TL increments exactly every 4 cycles (TL=1 after 4 edges, TL=2 after 8). With irq_en=0 and TL=FFFF_FFFF, overflow leaves IRQ=0.
- Collisions:
  - Write TL=100 on the same edge as a tick → TL=100.
  - Write TCON=3 (clear) on the same edge as an overflow with irq_en=1 → TCON=7 and IRQ=1.
- Decode: reads and writes at BASE+16 and at 32'h0000_0004 → no register changes and ReadData=0. Reads at BASE+3 return TH.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped interval timer that drives the CPU interrupt line.
//
// A 32-bit up-counter (TL) advances on every prescaler tick. When it wraps past
// 32'hFFFF_FFFF it reloads from TH, and if irq_en is set it latches status,
// which holds IRQ high until software clears it.
//
// Register map (word offsets from BASE, Addr[1:0] ignored):
//   0 TH   reload value
//   1 TL   counter
//   2 TCON {status, irq_en, enable} in bits [2:0]
//   3 PSC  prescaler compare value (PSC_W bits)
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous active-low reset
//   MemRd      bus read strobe
//   MemWr      bus write strobe
//   Addr       byte address
//   WriteData  write data
//   ReadData   combinational read data, 0 unless a read hits the block
//   IRQ        active-high interrupt request (status & irq_en)
module timer_irq #(
  parameter logic [31:0] BASE  = 32'h4000_0000,
  parameter int unsigned PSC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [31:0] TlMax = 32'hFFFF_FFFF;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic             status_q, status_d;
  logic             irq_en_q, irq_en_d;
  logic             enable_q, enable_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;

  logic       hit;
  logic [1:0] sel;
  logic       wr_th, wr_tl, wr_tcon, wr_psc;
  logic       tick;
  logic       overflow;

  assign hit = (Addr[31:4] == BASE[31:4]);
  assign sel = Addr[3:2];

  assign wr_th   = MemWr && hit && (sel == 2'd0);
  assign wr_tl   = MemWr && hit && (sel == 2'd1);
  assign wr_tcon = MemWr && hit && (sel == 2'd2);
  assign wr_psc  = MemWr && hit && (sel == 2'd3);

  assign tick = enable_q && (pcnt_q == psc_q);

  // A TL write discards a coincident tick, so it also suppresses the overflow.
  assign overflow = tick && !wr_tl && (tl_q == TlMax);

  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    status_d = status_q;
    irq_en_d = irq_en_q;
    enable_d = enable_q;
    psc_d    = psc_q;
    pcnt_d   = pcnt_q;

    // Prescaler advances only while enabled.
    if (enable_q) begin
      if (tick) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    // TL uses the old TH on overflow even if TH is written this cycle.
    if (wr_tl) begin
      tl_d = WriteData;
    end else if (tick) begin
      tl_d = (tl_q == TlMax) ? th_q : tl_q + 32'd1;
    end

    if (wr_th) begin
      th_d = WriteData;
    end

    if (wr_tl || wr_psc) begin
      pcnt_d = '0;
    end

    if (wr_psc) begin
      psc_d = WriteData[PSC_W-1:0];
    end

    // An overflow with the old irq_en set wins over a status clear.
    if (wr_tcon) begin
      status_d = WriteData[2] | (overflow & irq_en_q);
      irq_en_d = WriteData[1];
      enable_d = WriteData[0];
    end else begin
      status_d = status_q | (overflow & irq_en_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      status_q <= 1'b0;
      irq_en_q <= 1'b0;
      enable_q <= 1'b0;
      psc_q    <= '0;
      pcnt_q   <= '0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      enable_q <= enable_d;
      psc_q    <= psc_d;
      pcnt_q   <= pcnt_d;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRd && hit) begin
      unique case (sel)
        2'd0:    ReadData = th_q;
        2'd1:    ReadData = tl_q;
        2'd2:    ReadData = {29'h0, status_q, irq_en_q, enable_q};
        default: ReadData = 32'(psc_q);
      endcase
    end
  end

  assign IRQ = status_q & irq_en_q;

endmodule
